pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage pipeline. It drives the stall and flush enables of the Fetch→Decode and Decode→Execute pipeline registers, and the Execute-stage forwarding selects. It also tracks an instruction-fetch wait state when instruction memory is not ready, including wrong-path discard after a taken branch. It sits beside the datapath; it is purely control and carries no data.

Parameters:
REG_ADDR_WIDTH, 5, width of architectural register indices
WAIT_CNT_WIDTH, 4, width of the fetch-wait watchdog counter; timeout at all-ones

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
Rs1D, Rs2D  in  REG_ADDR_WIDTH  source registers in Decode
Rs1E, Rs2E, RdE  in  REG_ADDR_WIDTH  source and destination registers in Execute
RdM, RdW  in  REG_ADDR_WIDTH  destination registers in Memory and Writeback
RegWriteM, RegWriteW  in  1  register write enables in Memory and Writeback
LoadE  in  1  Execute instruction is a load (ResultSrcE selects memory)
PCSrcE  in  1  taken branch or jump resolved in Execute
imem_valid  in  1  instruction memory returns data this cycle
StallF, StallD  out  1  hold PC / hold the F→D register
FlushD, FlushE  out  1  bubble into the F→D / D→E register
ForwardAE, ForwardBE  out  2  ALU operand select: 00 register file, 01 Writeback, 10 Memory
fetch_timeout  out  1  sticky watchdog flag
stall_cycles, flush_count  out  32  performance counters (see Optional Feature)

Behaviour:
- Forwarding (combinational):
  - ForwardAE = 10 if RegWriteM & RdM≠0 & RdM==Rs1E.
  - Otherwise ForwardAE = 01 if RegWriteW & RdW≠0 & RdW==Rs1E.
  - Otherwise ForwardAE = 00.
  - ForwardBE uses the same rule with Rs2E.
  - Memory takes priority over Writeback.
- Load-use condition: lw = LoadE & RdE≠0 & (RdE==Rs1D | RdE==Rs2D).
- State machine (registered): RUN, IWAIT, DISCARD. Outputs are combinational from state and inputs.
- RUN:
  - PCSrcE → FlushD=1, FlushE=1, no stalls; next state RUN.
  - Else !imem_valid → StallF=1, FlushD=1; next state IWAIT.
  - Also, if lw with !imem_valid → StallD=1, FlushE=1, FlushD=0 (StallD beats FlushD).
  - Else lw → StallF=1, StallD=1, FlushE=1; next state RUN.
- IWAIT:
  - StallF=1, FlushD=1; lw still applies as in RUN.
  - PCSrcE → StallF=0 (PC loads target), FlushD=1, FlushE=1; next state DISCARD, or RUN if imem_valid that same cycle.
  - imem_valid → next state RUN, outputs as RUN for that cycle.
- DISCARD:
  - StallF=1, FlushD=1; the first imem_valid is dropped, then next state RUN.
  - PCSrcE takes the same action as in IWAIT.
- Watchdog: wait_cnt clears on entry to IWAIT or DISCARD and increments each cycle in those states, saturating. Reaching all-ones sets fetch_timeout, which stays set until rst. The state machine is not affected.
- Reset (rst high on an edge):
  - state=RUN, wait_cnt=0, fetch_timeout=0, counters=0.
  - While rst is high: FlushD=FlushE=1, StallF=StallD=0, ForwardAE=ForwardBE=00.
- Reset mid-IWAIT or DISCARD abandons the wait. The next cycle is RUN.

Optional Feature:
HAZARD_PERF_EN:
- Defined: stall_cycles increments on every non-reset cycle with StallF=1. flush_count increments on every non-reset cycle with FlushE=1. Both counters wrap at 2^32.
- Undefined: both ports are tied to 0 and no counter flops are instantiated.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - fetch_state_t enum: RUN, IWAIT, DISCARD.
- Sub-module hazard_fwd_unit, combinational, one instance per operand; outputs fwd_sel_t.

Test Plan:
- RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 → ForwardAE=10. With RdM=0 instead → 01. With Rs1E=0 → 00.
- LoadE=1, RdE=7, Rs2D=7, imem_valid=1 → exactly one cycle of StallF=StallD=FlushE=1. Next cycle with LoadE=0 → all 0.
- imem_valid low for 3 cycles → StallF=FlushD=1 for 3 cycles in IWAIT. RUN on the 4th cycle when valid.
- In IWAIT, PCSrcE=1 → StallF=0, FlushD=FlushE=1, state DISCARD. The next imem_valid is dropped, then RUN.
- imem_valid held low 15 cycles (WAIT_CNT_WIDTH=4) → fetch_timeout=1 and it stays set. rst for 1 cycle → 0, state RUN, FlushD=FlushE=1 during rst.
- HAZARD_PERF_EN defined: 2 load-use stalls + 1 branch flush → stall_cycles=2, flush_count=3.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects and fetch-wait states.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    IWAIT   = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational forwarding select for one Execute-stage ALU operand (Memory beats Writeback).
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs_e_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w_i,
  input  logic                      reg_write_m_i,
  input  logic                      reg_write_w_i,
  output fwd_sel_t                  fwd_sel_o
);

  always_comb begin
    fwd_sel_o = FWD_RF;
    if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i)) begin
      fwd_sel_o = FWD_MEM;
    end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i)) begin
      fwd_sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding control for the 5-stage pipeline with fetch-wait tracking and watchdog.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int WAIT_CNT_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic                      RegWriteM,
  input  logic                      RegWriteW,
  input  logic                      LoadE,
  input  logic                      PCSrcE,
  input  logic                      imem_valid,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic                      fetch_timeout,
  output logic [31:0]               stall_cycles,
  output logic [31:0]               flush_count
);

  localparam logic [WAIT_CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [1:0][REG_ADDR_WIDTH-1:0] rs_e;
  fwd_sel_t                       fwd_sel [2];

  assign rs_e = {Rs2E, Rs1E};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      hazard_fwd_unit #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
      ) u_fwd (
        .rs_e_i       (rs_e[gi]),
        .rd_m_i       (RdM),
        .rd_w_i       (RdW),
        .reg_write_m_i(RegWriteM),
        .reg_write_w_i(RegWriteW),
        .fwd_sel_o    (fwd_sel[gi])
      );
    end
  endgenerate

  assign ForwardAE = rst ? 2'b00 : fwd_sel[0];
  assign ForwardBE = rst ? 2'b00 : fwd_sel[1];

  fetch_state_t              state_q, state_d;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
  logic                      timeout_q, timeout_d;
  logic                      lw;

  assign lw = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    state_d = state_q;
    StallF  = 1'b0;
    StallD  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (PCSrcE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (!imem_valid) begin
          StallF  = 1'b1;
          FlushD  = !lw;
          StallD  = lw;
          FlushE  = lw;
          state_d = IWAIT;
        end else if (lw) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
      IWAIT, DISCARD: begin
        if (PCSrcE) begin
          // PC takes the branch target; whatever fetch is outstanding is wrong-path.
          FlushD  = 1'b1;
          FlushE  = 1'b1;
          state_d = imem_valid ? RUN : DISCARD;
        end else if (imem_valid && (state_q == IWAIT)) begin
          StallF  = lw;
          StallD  = lw;
          FlushE  = lw;
          state_d = RUN;
        end else begin
          // Still waiting, or dropping the first wrong-path word returned in DISCARD.
          StallF = 1'b1;
          FlushD = !lw;
          StallD = lw;
          FlushE = lw;
          if (imem_valid) begin
            state_d = RUN;
          end
        end
      end
      default: state_d = RUN;
    endcase
    if (rst) begin
      StallF = 1'b0;
      StallD = 1'b0;
      FlushD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if ((state_d != RUN) && (state_d != state_q)) begin
      wait_cnt_d = '0;
    end else if ((state_q != RUN) && (wait_cnt_q != CNT_MAX)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    timeout_d = timeout_q || ((state_q != RUN) && (wait_cnt_d == CNT_MAX));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign fetch_timeout = timeout_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (StallF) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (FlushE) flush_count_q  <= flush_count_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; ctrl vectors are {StallF, StallD, FlushD, FlushE}.
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteM, RegWriteW, LoadE, PCSrcE, imem_valid;
  logic        StallF, StallD, FlushD, FlushE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        fetch_timeout;
  logic [31:0] stall_cycles, flush_count;

  int checks = 0;
  int passes = 0;

  pipeline_hazard_ctrl #(
    .REG_ADDR_WIDTH(5),
    .WAIT_CNT_WIDTH(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .Rs1D         (Rs1D),
    .Rs2D         (Rs2D),
    .Rs1E         (Rs1E),
    .Rs2E         (Rs2E),
    .RdE          (RdE),
    .RdM          (RdM),
    .RdW          (RdW),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .LoadE        (LoadE),
    .PCSrcE       (PCSrcE),
    .imem_valid   (imem_valid),
    .StallF       (StallF),
    .StallD       (StallD),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .fetch_timeout(fetch_timeout),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [3:0] ctrl = {StallF, StallD, FlushD, FlushE};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    LoadE = 1'b0; PCSrcE = 1'b0; imem_valid = 1'b1;
  endtask

  task automatic load_use;
    LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
  endtask

  task automatic reset_dut;
    tick; rst = 1'b1; idle;
    tick; rst = 1'b0;
  endtask

  task automatic test_reset;
    tick; rst = 1'b1; idle;
    RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5;
    RegWriteW = 1'b1; RdW = 5'd6; Rs2E = 5'd6;
    @(negedge clk);
    checks++; if (ctrl !== 4'b0011) $display("FAIL reset_ctrl got %b want 0011", ctrl); else passes++;
    checks++; if (ForwardAE !== 2'b00) $display("FAIL reset_fwdA got %b want 00", ForwardAE); else passes++;
    checks++; if (ForwardBE !== 2'b00) $display("FAIL reset_fwdB got %b want 00", ForwardBE); else passes++;
    tick;
    @(negedge clk);
    checks++; if (fetch_timeout !== 1'b0) $display("FAIL reset_timeout got %b want 0", fetch_timeout); else passes++;
    checks++; if (stall_cycles !== 32'd0 || flush_count !== 32'd0)
      $display("FAIL reset_counters got %0d/%0d want 0/0", stall_cycles, flush_count); else passes++;
    tick; rst = 1'b0; idle;
    @(negedge clk);
    checks++; if (ctrl !== 4'b0000) $display("FAIL post_reset_ctrl got %b want 0000", ctrl); else passes++;
    $display("reset: ctrl=%b fwdA=%b fwdB=%b", ctrl, ForwardAE, ForwardBE);
  endtask

  task automatic test_forwarding;
    tick; idle;
    RegWriteM = 1'b1; RdM = 5'd5; RegWriteW = 1'b1; RdW = 5'd5; Rs1E = 5'd5;
    @(negedge clk);
    checks++; if (ForwardAE !== 2'b10) $display("FAIL fwdA_mem got %b want 10", ForwardAE); else passes++;
    $display("fwd: RdM=5 RdW=5 Rs1E=5 -> A=%b", ForwardAE);
    RdM = 5'd0;
    #1;
    checks++; if (ForwardAE !== 2'b01) $display("FAIL fwdA_wb got %b want 01", ForwardAE); else passes++;
    $display("fwd: RdM=0 RdW=5 Rs1E=5 -> A=%b", ForwardAE);
    RdM = 5'd5; Rs1E = 5'd0;
    #1;
    checks++; if (ForwardAE !== 2'b00) $display("FAIL fwdA_x0 got %b want 00", ForwardAE); else passes++;
    $display("fwd: Rs1E=0 -> A=%b", ForwardAE);
    RdM = 5'd3; RdW = 5'd9; Rs2E = 5'd9;
    #1;
    checks++; if (ForwardBE !== 2'b01) $display("FAIL fwdB_wb got %b want 01", ForwardBE); else passes++;
    $display("fwd: RdM=3 RdW=9 Rs2E=9 -> B=%b", ForwardBE);
    RdM = 5'd9;
    #1;
    checks++; if (ForwardBE !== 2'b10) $display("FAIL fwdB_mem got %b want 10", ForwardBE); else passes++;
    $display("fwd: RdM=9 RdW=9 Rs2E=9 -> B=%b", ForwardBE);
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    #1;
    checks++; if (ForwardBE !== 2'b00) $display("FAIL fwdB_nowrite got %b want 00", ForwardBE); else passes++;
    $display("fwd: no writes -> B=%b", ForwardBE);
  endtask

  task automatic test_load_use;
    tick; idle; load_use;
    @(negedge clk);
    checks++; if (ctrl !== 4'b1101) $display("FAIL load_use got %b want 1101", ctrl); else passes++;
    $display("load_use: ctrl=%b", ctrl);
    tick; idle;
    @(negedge clk);
    checks++; if (ctrl !== 4'b0000) $display("FAIL load_use_release got %b want 0000", ctrl); else passes++;
    $display("load_use release: ctrl=%b", ctrl);
  endtask

  task automatic test_iwait;
    for (int i = 0; i < 3; i++) begin
      tick; idle; imem_valid = 1'b0;
      @(negedge clk);
      checks++; if (ctrl !== 4'b1010) $display("FAIL iwait_%0d got %b want 1010", i, ctrl); else passes++;
      $display("iwait cycle %0d: ctrl=%b", i, ctrl);
    end
    for (int i = 0; i < 2; i++) begin
      tick; idle;
      @(negedge clk);
      checks++; if (ctrl !== 4'b0000) $display("FAIL iwait_resume_%0d got %b want 0000", i, ctrl); else passes++;
      $display("iwait resume %0d: ctrl=%b", i, ctrl);
    end
  endtask

  task automatic test_discard;
    tick; idle; imem_valid = 1'b0;
    tick; PCSrcE = 1'b1;
    @(negedge clk);
    checks++; if (ctrl !== 4'b0011) $display("FAIL discard_branch got %b want 0011", ctrl); else passes++;
    $display("discard branch in IWAIT: ctrl=%b", ctrl);
    tick; PCSrcE = 1'b0;
    @(negedge clk);
    checks++; if (ctrl !== 4'b1010) $display("FAIL discard_wait got %b want 1010", ctrl); else passes++;
    tick; imem_valid = 1'b1;
    @(negedge clk);
    checks++; if (ctrl !== 4'b1010) $display("FAIL discard_drop got %b want 1010", ctrl); else passes++;
    $display("discard drop: ctrl=%b", ctrl);
    tick;
    @(negedge clk);
    checks++; if (ctrl !== 4'b0000) $display("FAIL discard_resume got %b want 0000", ctrl); else passes++;
    $display("discard resume: ctrl=%b", ctrl);
  endtask

  task automatic test_back_to_back;
    tick; idle; load_use; imem_valid = 1'b0;
    @(negedge clk);
    checks++; if (ctrl !== 4'b1101) $display("FAIL lw_nofetch got %b want 1101", ctrl); else passes++;
    $display("lw + no fetch: ctrl=%b", ctrl);
    tick; idle; load_use; PCSrcE = 1'b1;
    @(negedge clk);
    checks++; if (ctrl !== 4'b0011) $display("FAIL branch_beats_lw got %b want 0011", ctrl); else passes++;
    $display("branch + lw in IWAIT: ctrl=%b", ctrl);
    tick; idle;
    @(negedge clk);
    checks++; if (ctrl !== 4'b0000) $display("FAIL branch_valid_run got %b want 0000", ctrl); else passes++;
  endtask

  task automatic test_timeout;
    reset_dut;
    tick; idle; imem_valid = 1'b0;
    repeat (9) tick;
    @(negedge clk);
    checks++; if (fetch_timeout !== 1'b0) $display("FAIL timeout_early got %b want 0", fetch_timeout); else passes++;
    repeat (10) tick;
    @(negedge clk);
    checks++; if (fetch_timeout !== 1'b1) $display("FAIL timeout_set got %b want 1", fetch_timeout); else passes++;
    checks++; if (ctrl !== 4'b1010) $display("FAIL timeout_fsm got %b want 1010", ctrl); else passes++;
    $display("timeout: flag=%b ctrl=%b", fetch_timeout, ctrl);
    tick; PCSrcE = 1'b1;
    @(negedge clk);
    checks++; if (fetch_timeout !== 1'b1) $display("FAIL timeout_sticky got %b want 1", fetch_timeout); else passes++;
    tick; PCSrcE = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++; if (ctrl !== 4'b0011) $display("FAIL rst_in_discard got %b want 0011", ctrl); else passes++;
    tick; rst = 1'b0; imem_valid = 1'b1;
    @(negedge clk);
    checks++; if (fetch_timeout !== 1'b0) $display("FAIL timeout_clear got %b want 0", fetch_timeout); else passes++;
    checks++; if (ctrl !== 4'b0000) $display("FAIL rst_abandon got %b want 0000", ctrl); else passes++;
    $display("after reset: flag=%b ctrl=%b", fetch_timeout, ctrl);
  endtask

  task automatic test_perf;
    int exp_stall;
    int exp_flush;
`ifdef HAZARD_PERF_EN
    exp_stall = 2;
    exp_flush = 3;
`else
    exp_stall = 0;
    exp_flush = 0;
`endif
    reset_dut;
    tick; idle; load_use;
    tick; idle;
    tick; idle; load_use;
    tick; idle;
    tick; idle; PCSrcE = 1'b1;
    tick; idle;
    @(negedge clk);
    checks++; if (stall_cycles !== 32'(exp_stall)) $display("FAIL perf_stall got %0d want %0d", stall_cycles, exp_stall); else passes++;
    checks++; if (flush_count !== 32'(exp_flush)) $display("FAIL perf_flush got %0d want %0d", flush_count, exp_flush); else passes++;
    $display("perf: stall_cycles=%0d flush_count=%0d", stall_cycles, flush_count);
  endtask

  initial begin
    rst = 1'b1;
    idle;
    repeat (2) @(posedge clk);
    test_reset;
    test_perf;
    test_forwarding;
    test_load_use;
    test_iwait;
    test_discard;
    test_back_to_back;
    test_timeout;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
